// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types and constants for the instruction fetch unit.
`default_nettype none

package ifu_pkg;

  typedef enum logic [2:0] {
    REQ   = 3'd0,
    WAIT  = 3'd1,
    HOLD  = 3'd2,
    NPC   = 3'd3,
    FAULT = 3'd4
  } ifu_state_e;

  localparam logic [1:0] CAUSE_NONE     = 2'd0;
  localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
  localparam logic [1:0] CAUSE_BUS_ERR  = 2'd2;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'd3;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

endpackage

`default_nettype wire

// File: rtl/ifu_timeout_cnt.sv
// ifu_timeout_cnt: counts wait cycles; expired_o flags the cycle in which the
// count reaches TIMEOUT (never when TIMEOUT is 0).
`default_nettype none

module ifu_timeout_cnt #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [CNT_W:0] LIMIT = (CNT_W+1)'(TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   w_next;

  assign w_next = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};

  // Expiry is judged on the value the counter is about to take, so TIMEOUT
  // equals the number of wait cycles tolerated.
  assign expired_o = en_i && (TIMEOUT != 0) && (w_next == LIMIT);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = w_next[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ifu_fetch.sv
// ifu_fetch: owns the PC, issues one imem word read at a time, holds the
// returned instruction for decode and waits for execute's next PC.
`default_nettype none

module ifu_fetch
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned TIMEOUT  = 255,
  parameter int unsigned CNT_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        imem_resp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        npc_valid,
  input  logic [31:0] npc,
  output logic        fetch_fault,
  output logic [1:0]  fault_cause,
  output logic [31:0] fetch_count
);

  ifu_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic [1:0]  cause_q, cause_d;
  logic [31:0] count_q, count_d;

  logic w_cnt_clear;
  logic w_cnt_en;
  logic w_expired;
  logic w_take_npc;

  ifu_timeout_cnt #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (w_cnt_clear),
    .en_i      (w_cnt_en),
    .expired_o (w_expired)
  );

  // Request valid is a state decode, so gate it with rst to keep it low
  // while reset is held.
  assign imem_req_valid = (state_q == REQ) && !rst;
  assign imem_req_addr  = pc_q;
  assign inst_valid     = (state_q == HOLD);
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;
  assign fetch_fault    = (state_q == FAULT);
  assign fault_cause    = cause_q;
  assign fetch_count    = count_q;

  assign w_take_npc = npc_valid &&
                      (((state_q == HOLD) && inst_ready) || (state_q == NPC));

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    inst_pc_d   = inst_pc_q;
    cause_d     = cause_q;
    count_d     = count_q;
    w_cnt_clear = 1'b0;
    w_cnt_en    = 1'b0;

    case (state_q)
      REQ: begin
        if (imem_req_ready) begin
          state_d     = WAIT;
          w_cnt_clear = 1'b1;
        end
      end
      WAIT: begin
        w_cnt_en = 1'b1;
        if (imem_resp_valid) begin
          if (imem_resp_err) begin
            state_d = FAULT;
            cause_d = CAUSE_BUS_ERR;
          end else begin
            inst_d    = imem_resp_data;
            inst_pc_d = pc_q;
            state_d   = HOLD;
          end
        end else if (w_expired) begin
          state_d = FAULT;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      HOLD: begin
        if (inst_ready) begin
          count_d = count_q + 32'd1;
          state_d = NPC;
        end
      end
      NPC:     state_d = NPC;
      FAULT:   state_d = FAULT;
      default: state_d = FAULT;
    endcase

    // A next PC accepted in the handshake cycle skips the NPC state.
    if (w_take_npc) begin
      pc_d = npc;
      if (npc[1:0] == 2'b00) begin
        state_d = REQ;
      end else begin
        state_d = FAULT;
        cause_d = CAUSE_MISALIGN;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= REQ;
      pc_q      <= RESET_PC;
      inst_q    <= '0;
      inst_pc_q <= '0;
      cause_q   <= CAUSE_NONE;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      cause_q   <= cause_d;
      count_q   <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed and randomized checks of ifu_fetch against a
// transaction-level model of the fetch protocol.
`default_nettype none

module tb_ifu_fetch;

  localparam int unsigned TO = 4;
  localparam logic [31:0] RPC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        imem_resp_err = 1'b0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        npc_valid = 1'b0;
  logic [31:0] npc = '0;
  logic        fetch_fault;
  logic [1:0]  fault_cause;
  logic [31:0] fetch_count;

  ifu_fetch #(
    .RESET_PC (RPC),
    .TIMEOUT  (TO),
    .CNT_W    (8)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .imem_resp_err   (imem_resp_err),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .npc_valid       (npc_valid),
    .npc             (npc),
    .fetch_fault     (fetch_fault),
    .fault_cause     (fault_cause),
    .fetch_count     (fetch_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Model: a fetch is either idle-requesting, outstanding, holding an
  // instruction, awaiting a next PC, or dead with a recorded cause.
  logic [31:0] m_pc, m_inst, m_inst_pc, m_count;
  logic [1:0]  m_cause;
  bit          m_fault, m_busy, m_have, m_need_npc;
  int          m_waited;

  function automatic void model_reset();
    m_pc = RPC; m_inst = '0; m_inst_pc = '0; m_count = '0; m_cause = 2'd0;
    m_fault = 0; m_busy = 0; m_have = 0; m_need_npc = 0; m_waited = 0;
  endfunction

  function automatic void take_npc(logic [31:0] target);
    m_pc = target;
    if (target[1:0] != 2'b00) begin
      m_fault = 1;
      m_cause = 2'd1;
    end
  endfunction

  function automatic void model_step();
    if (rst) begin
      model_reset();
    end else if (m_fault) begin
      m_fault = 1;
    end else if (m_have) begin
      if (inst_ready) begin
        m_count++;
        m_have = 0;
        if (npc_valid) take_npc(npc);
        else m_need_npc = 1;
      end
    end else if (m_need_npc) begin
      if (npc_valid) begin
        m_need_npc = 0;
        take_npc(npc);
      end
    end else if (m_busy) begin
      m_waited++;
      if (imem_resp_valid) begin
        m_busy = 0;
        if (imem_resp_err) begin
          m_fault = 1; m_cause = 2'd2;
        end else begin
          m_have = 1; m_inst = imem_resp_data; m_inst_pc = m_pc;
        end
      end else if (TO != 0 && m_waited == int'(TO)) begin
        m_busy = 0; m_fault = 1; m_cause = 2'd3;
      end
    end else if (imem_req_ready) begin
      m_busy = 1;
      m_waited = 0;
    end
  endfunction

  function automatic bit m_in_req();
    return !m_fault && !m_busy && !m_have && !m_need_npc;
  endfunction

  // Compare process: every negedge, DUT outputs against the model.
  always @(negedge clk) begin
    chk("req_valid", {31'd0, imem_req_valid}, {31'd0, (!rst && m_in_req())});
    chk("req_addr", imem_req_addr, m_pc);
    chk("inst_valid", {31'd0, inst_valid}, {31'd0, m_have});
    chk("inst", inst, m_inst);
    chk("inst_pc", inst_pc, m_inst_pc);
    chk("fetch_fault", {31'd0, fetch_fault}, {31'd0, m_fault});
    chk("fault_cause", {30'd0, fault_cause}, {30'd0, m_cause});
    chk("fetch_count", fetch_count, m_count);
  end

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clear_inputs();
    imem_req_ready = 0; imem_resp_valid = 0; imem_resp_err = 0;
    inst_ready = 0; npc_valid = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    model_reset();
    clear_inputs();
    cyc();
    cyc();
    rst = 0;
  endtask

  logic [31:0] tmp;
  logic [31:0] held;

  initial begin
    model_reset();
    repeat (3) cyc();
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_count", fetch_count, 32'd0);

    // First fetch, handshake together with the next PC.
    rst = 0;
    imem_req_ready = 1;
    #1 chk("first_addr", imem_req_addr, 32'h8000_0000);
    cyc();
    imem_req_ready = 0;
    imem_resp_valid = 1; imem_resp_data = 32'h0000_0413;
    cyc();
    imem_resp_valid = 0;
    chk("first_inst", inst, 32'h0000_0413);
    chk("first_inst_pc", inst_pc, 32'h8000_0000);
    inst_ready = 1; npc_valid = 1; npc = 32'h8000_0004;
    cyc();
    inst_ready = 0; npc_valid = 0;
    chk("second_addr", imem_req_addr, 32'h8000_0004);
    chk("second_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("count_one", fetch_count, 32'd1);

    // Backpressure, then a delayed next PC.
    imem_req_ready = 1;
    cyc();
    imem_req_ready = 0;
    held = $urandom;
    imem_resp_valid = 1; imem_resp_data = held;
    cyc();
    imem_resp_valid = 0;
    npc_valid = 1; npc = 32'h8000_0040;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("stall_inst", inst, held);
      chk("stall_req_valid", {31'd0, imem_req_valid}, 32'd0);
    end
    npc_valid = 0; inst_ready = 1;
    cyc();
    inst_ready = 0;
    cyc();
    cyc();
    chk("npc_wait_valid", {31'd0, inst_valid}, 32'd0);
    npc_valid = 1; npc = 32'h8000_0100;
    cyc();
    npc_valid = 0;
    chk("jump_addr", imem_req_addr, 32'h8000_0100);

    // Misaligned next PC.
    imem_req_ready = 1;
    cyc();
    imem_req_ready = 0; imem_resp_valid = 1; imem_resp_data = $urandom;
    cyc();
    imem_resp_valid = 0;
    inst_ready = 1; npc_valid = 1; npc = 32'h8000_0006;
    cyc();
    chk("misalign_cause", {30'd0, fault_cause}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      imem_req_ready = 1;
      imem_resp_valid = 1'($urandom);
      npc_valid = 1'($urandom);
      npc = 32'h8000_0200;
      cyc();
      chk("fault_no_req", {31'd0, imem_req_valid}, 32'd0);
    end

    // Bus error.
    do_reset();
    imem_req_ready = 1;
    cyc();
    imem_req_ready = 0; imem_resp_valid = 1; imem_resp_err = 1;
    cyc();
    clear_inputs();
    chk("buserr_cause", {30'd0, fault_cause}, 32'd2);
    chk("buserr_inst_valid", {31'd0, inst_valid}, 32'd0);

    // Timeout, and a response in the deciding cycle.
    do_reset();
    imem_req_ready = 1;
    cyc();
    imem_req_ready = 0;
    repeat (3) cyc();
    chk("to_not_yet", {31'd0, fetch_fault}, 32'd0);
    cyc();
    chk("to_cause", {30'd0, fault_cause}, 32'd3);
    do_reset();
    imem_req_ready = 1;
    cyc();
    imem_req_ready = 0;
    repeat (3) cyc();
    imem_resp_valid = 1; imem_resp_data = 32'h0000_0013;
    cyc();
    imem_resp_valid = 0;
    chk("to_race_inst", inst, 32'h0000_0013);
    chk("to_race_fault", {31'd0, fetch_fault}, 32'd0);

    // Reset during WAIT, then a stale response in REQ.
    do_reset();
    imem_req_ready = 1;
    cyc();
    imem_req_ready = 0;
    cyc();
    rst = 1;
    model_reset();
    #1 chk("async_rst_valid", {31'd0, inst_valid | imem_req_valid}, 32'd0);
    cyc();
    rst = 0;
    imem_resp_valid = 1; imem_resp_data = 32'hdead_beef;
    cyc();
    imem_resp_valid = 0;
    chk("stale_addr", imem_req_addr, 32'h8000_0000);
    chk("stale_inst", inst, 32'd0);
    chk("stale_valid", {31'd0, inst_valid}, 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      if (m_fault && ($urandom % 4 == 0)) begin
        do_reset();
      end else if ($urandom % 400 == 0) begin
        rst = 1;
        model_reset();
        clear_inputs();
        cyc();
        rst = 0;
      end
      imem_req_ready  = ($urandom % 3) != 0;
      imem_resp_data  = $urandom;
      imem_resp_err   = ($urandom % 32) == 0;
      if (m_busy)                      imem_resp_valid = 1'($urandom);
      else if (m_in_req() || m_fault)  imem_resp_valid = ($urandom % 8) == 0;
      else                             imem_resp_valid = 0;
      inst_ready = 1'($urandom);
      npc_valid  = 1'($urandom);
      tmp = $urandom;
      if (tmp[5:0] == 6'd0)     npc = m_pc + 32'd2;
      else if (tmp[5:0] < 6'd40) npc = m_inst_pc + 32'd4;
      else begin
        tmp = $urandom;
        npc = tmp & 32'hffff_fffc;
      end
      cyc();
    end

    clear_inputs();
    cyc();
    @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
